// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_pkg
//  Description : Shared types and constants for the 2x2 matrix-multiply
//                front-end sequencer and its core wrapper.
//                  state_t       - sequencer FSM states
//                  NUM_OPERANDS  - operand bytes per full load (A then B)
//                  NUM_RESULTS   - product elements per run (C00..C11)
//                  FIRST_B_SEL   - core sel_in index of B00
//                  DATA_W_DEF / RES_W_DEF - default operand / result widths
//  Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int RES_W_DEF    = 17;
  localparam int NUM_OPERANDS = 8;
  localparam int NUM_RESULTS  = 4;
  localparam int FIRST_B_SEL  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FLUSH   = 3'd2,
    SETTLE  = 3'd3,
    PRESENT = 3'd4
  } state_t;

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_sequencer
//  Description : Front-end control stage for the 2x2 matrix-multiply core.
//                Accepts 8 operand bytes (A00,A01,A10,A11,B00,B01,B10,B11)
//                over valid/ready, writes them into the core through its
//                sel_in/input_val interface, raises execute, walks sel_out
//                through C00..C11 and returns each product as a valid/ready
//                result stream tagged with its element index.
//  Ports       : clk, reset (async, active-low)
//                in_valid/in_data/in_ready      operand byte stream
//                mm_sel_in/mm_input_val/mm_execute/mm_sel_out/mm_result
//                                               core interface
//                out_valid/out_data/out_idx/out_ready  result stream
//                busy (not IDLE), done (pulse after C11 accepted)
//                reuse_a (only with MATMUL_SEQ_REUSE_A_EN)
//  Options     : MATMUL_SEQ_REUSE_A_EN - adds reuse_a; when set on the first
//                handshake only B (4 bytes, sel_in 4..7) is loaded and the
//                core keeps A from the previous run.
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int RES_W         = RES_W_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MATMUL_SEQ_REUSE_A_EN
  input  logic              reuse_a,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [2:0]        mm_sel_in,
  output logic [DATA_W-1:0] mm_input_val,
  output logic              mm_execute,
  output logic [1:0]        mm_sel_out,
  input  logic [RES_W-1:0]  mm_result,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_data,
  output logic [1:0]        out_idx,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] c_last_sel  = 3'(NUM_OPERANDS - 1);
  localparam logic [2:0] c_first_b   = 3'(FIRST_B_SEL);
  localparam logic [1:0] c_last_res  = 2'(NUM_RESULTS - 1);
  localparam logic [2:0] c_settle    = 3'(SETTLE_CYCLES);

  state_t     r_state;
  logic [2:0] r_cnt;     // sel_in index of the next operand
  logic [2:0] r_settle;  // cycles left before sampling mm_result

  logic w_in_hs;
  logic w_reuse;

  assign w_in_hs = in_valid & in_ready;

`ifdef MATMUL_SEQ_REUSE_A_EN
  assign w_reuse = reuse_a;
`else
  assign w_reuse = 1'b0;
`endif

  // mm_sel_in / mm_input_val change only on an accepted byte. The core
  // rewrites the selected element every edge while execute is low, so
  // holding the last pair keeps those rewrites harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_settle     <= 3'd0;
      in_ready     <= 1'b1;
      mm_sel_in    <= 3'd0;
      mm_input_val <= '0;
      mm_execute   <= 1'b0;
      mm_sel_out   <= 2'd0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx      <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_in_hs) begin
            mm_input_val <= in_data;
            busy         <= 1'b1;
            r_state      <= LOAD;
            if (w_reuse) begin
              mm_sel_in <= c_first_b;
              r_cnt     <= c_first_b + 3'd1;
            end else begin
              mm_sel_in <= 3'd0;
              r_cnt     <= 3'd1;
            end
          end
        end

        LOAD: begin
          if (w_in_hs) begin
            mm_sel_in    <= r_cnt;
            mm_input_val <= in_data;
            r_cnt        <= r_cnt + 3'd1;
            if (r_cnt == c_last_sel) begin
              in_ready <= 1'b0;
              r_state  <= FLUSH;
            end
          end
        end

        // The core writes the last operand on this edge; execute goes high
        // only afterwards.
        FLUSH: begin
          mm_execute <= 1'b1;
          mm_sel_out <= 2'd0;
          r_settle   <= c_settle;
          r_state    <= SETTLE;
        end

        SETTLE: begin
          if (r_settle == 3'd0) begin
            out_data  <= mm_result;
            out_idx   <= mm_sel_out;
            out_valid <= 1'b1;
            r_state   <= PRESENT;
          end else begin
            r_settle <= r_settle - 3'd1;
          end
        end

        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (mm_sel_out == c_last_res) begin
              mm_execute <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
              in_ready   <= 1'b1;
              r_state    <= IDLE;
            end else begin
              mm_sel_out <= mm_sel_out + 2'd1;
              r_settle   <= c_settle;
              r_state    <= SETTLE;
            end
          end
        end

        default: begin
          r_state  <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule : matmul_sequencer
`default_nettype wire

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Front-end control stage placed directly upstream of the 2x2 matrix-multiply core.
- Accepts a byte stream of 8 operands over a valid/ready handshake and writes them into the core through its select/value/execute interface.
- Then raises execute, steps the core's output select through C00, C01, C10, C11, and returns the four 17-bit products as a valid/ready result stream.

Parameters:
- DATA_W, 8, operand width; matches core input_val.
- RES_W, 17, result width; matches core result.
- SETTLE_CYCLES, 1, cycles waited after changing mm_sel_out before sampling mm_result (range 0..7).

Ports:
- clk  in  1  single clock, shared with the core.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand byte valid.
- in_data  in  DATA_W  operand byte. Order: A00, A01, A10, A11, B00, B01, B10, B11.
- in_ready  out  1  sequencer can accept an operand.
- mm_sel_in  out  3  to core sel_in.
- mm_input_val  out  DATA_W  to core input_val.
- mm_execute  out  1  to core execute.
- mm_sel_out  out  2  to core sel_out.
- mm_result  in  RES_W  from core result.
- out_valid  out  1  result word valid.
- out_data  out  RES_W  captured result.
- out_idx  out  2  element index of out_data: 0=C00, 1=C01, 2=C10, 3=C11.
- out_ready  in  1  consumer accepts result.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after C11 is accepted.

Behaviour:
- Clock/reset: one clock. Reset is asynchronous and active-low, applied on the falling edge of reset. All outputs are registered.
- Reset values:
  - state = IDLE.
  - mm_sel_in = 0, mm_input_val = 0, mm_execute = 0, mm_sel_out = 0.
  - out_valid = 0, out_data = 0, out_idx = 0.
  - done = 0, busy = 0, in_ready = 1.
- Core write hazard: the core writes input_val into the element selected by sel_in on every edge while execute = 0. The sequencer therefore holds mm_sel_in and mm_input_val at the last written pair whenever no new byte is accepted, so repeated writes are idempotent.
- States:
  - IDLE: in_ready = 1, mm_execute = 0. A handshake (in_valid & in_ready) registers mm_sel_in <= 0 and mm_input_val <= in_data; set cnt = 1; go to LOAD.
  - LOAD: in_ready = 1. Each handshake registers mm_sel_in <= cnt and mm_input_val <= in_data, then cnt++. On the handshake with cnt = 7: in_ready <= 0, go to FLUSH. Gaps in in_valid are allowed; state and outputs hold.
  - FLUSH: one cycle. The core captures the 8th operand. Then mm_execute <= 1, mm_sel_out <= 0, settle counter <= SETTLE_CYCLES, go to SETTLE.
  - SETTLE: decrement the counter. When it is 0: out_data <= mm_result, out_idx <= mm_sel_out, out_valid <= 1, go to PRESENT.
  - PRESENT: hold out_valid, out_data and out_idx until out_ready.
    - On handshake with mm_sel_out < 3: out_valid <= 0, mm_sel_out++, reload the settle counter, go to SETTLE.
    - On handshake with mm_sel_out = 3: out_valid <= 0, mm_execute <= 0, done <= 1, go to IDLE.
- Latency:
  - Last operand handshake to first out_valid = SETTLE_CYCLES + 2 cycles.
  - With out_ready held high, one result every SETTLE_CYCLES + 2 cycles.
- in_ready is 0 in FLUSH, SETTLE and PRESENT; in_valid is ignored there.
- out_ready while out_valid = 0 is ignored.
- No arithmetic in this block; result width is passed through unchanged (max 2·255·255 = 130050 fits in 17 bits).
- Reset asserted mid-operation aborts immediately to the reset values. Partially loaded core contents are not restored; the core is cleared by the same reset.
- done and a new in_valid in the same cycle: done pulses and the new byte is accepted in IDLE on the next cycle (in_ready is already 1).

Optional Feature:
- Macro: MATMUL_SEQ_REUSE_A_EN.
- Defined:
  - Adds input port reuse_a (1 bit), sampled on the IDLE handshake.
  - If reuse_a = 1, the first byte is B00 written at sel_in 4. cnt starts at 5, only 4 bytes are taken, and the A matrix is kept from the previous run.
- Undefined:
  - No reuse_a port.
  - Always 8 bytes starting at sel_in 0.

Decomposition:
- Package matmul_pkg:
  - state enum (IDLE, LOAD, FLUSH, SETTLE, PRESENT).
  - NUM_OPERANDS = 8, NUM_RESULTS = 4, FIRST_B_SEL = 4.
  - Default DATA_W/RES_W constants, shared with the core wrapper.
- No sub-module needed; the settle counter and operand counter are inline registers.

Test Plan:
- Basic product: A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1 → results 19, 22, 43, 50 with out_idx 0..3; done pulses once; busy then returns to 0.
- Saturating inputs: all 8 bytes 255 → four results each 130050; no truncation.
- Backpressure and gaps: in_valid toggled every other cycle, out_ready low for 5 cycles per result → results unchanged and out_data stable while out_valid=1 & !out_ready; in_ready=0 after the 8th byte.
- Reset mid-load: assert reset after 5 bytes → all outputs at reset values; a following full load of A=I, B=[[9,8],[7,6]] yields 9, 8, 7, 6.
- SETTLE_CYCLES=0 and 7: first out_valid is 2 and 9 cycles respectively after the last operand handshake.
- MATMUL_SEQ_REUSE_A_EN: run 1 loads A=[[1,2],[3,4]], B=I → 1, 2, 3, 4. Run 2 with reuse_a=1 and 4 bytes B=[[2,0],[0,2]] → 2, 4, 6, 8; mm_sel_in never below 4 in run 2.
